// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with packet-locked round-robin or fixed-priority
// arbitration, a forced-select override and one registered output stage.
module stream_mux_rr #(
    parameter int NCH  = 8,
    parameter int W    = 8,
    parameter int SELW = 3,
    parameter int RR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH-1:0]    in_last,
    output logic [NCH-1:0]    in_ready,
    input  logic              force_en,
    input  logic [SELW-1:0]   force_sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [SELW-1:0]   out_ch,
    input  logic              out_ready
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_r, state_nx;
    logic [SELW-1:0] lock_ch_r, rr_ptr_r, grant_s, rr_next_s;
    logic            lock_forced_r, grant_vld_s, load_s, xfer_s, xfer_last_s, pkt_forced_s;
    logic [W-1:0]    xfer_data_s;

    assign load_s       = !out_valid || out_ready;
    assign xfer_s       = |in_ready;
    assign xfer_last_s  = |(in_ready & in_last);
    // a packet opened under force keeps that status until its last beat, whatever force_en does
    assign pkt_forced_s = (state_r == LOCKED) ? lock_forced_r : force_en;
    assign rr_next_s    = (grant_s == SELW'(NCH - 1)) ? {SELW{1'b0}} : grant_s + SELW'(1);

    // candidate grant: lock holder, forced channel, or arbitration winner
    always_comb begin
        logic [SELW:0]   sum;
        logic [SELW-1:0] idx;
        sum         = '0;
        idx         = '0;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        if (state_r == LOCKED) begin
            grant_s     = lock_ch_r;
            grant_vld_s = 1'b1;
        end else if (force_en) begin
            if ({1'b0, force_sel} < (SELW+1)'(NCH)) begin
                grant_s     = force_sel;
                grant_vld_s = in_valid[force_sel];
            end else begin
                grant_vld_s = 1'b0;
            end
        end else if (RR != 0) begin
            // scan from the far end so the channel nearest rr_ptr is written last
            for (int k = NCH - 1; k >= 0; k--) begin
                sum = {1'b0, rr_ptr_r} + (SELW+1)'(k);
                if (sum >= (SELW+1)'(NCH)) begin
                    sum = sum - (SELW+1)'(NCH);
                end else begin
                    sum = sum;
                end
                idx = sum[SELW-1:0];
                if (in_valid[idx]) begin
                    grant_s     = idx;
                    grant_vld_s = 1'b1;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    grant_s     = SELW'(k);
                    grant_vld_s = 1'b1;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // per-channel accept and data steering for the granted channel
    always_comb begin
        in_ready    = '0;
        xfer_data_s = '0;
        for (int c = 0; c < NCH; c++) begin
            in_ready[c] = !rst && load_s && grant_vld_s && (grant_s == SELW'(c)) && in_valid[c];
            if (grant_s == SELW'(c)) begin
                xfer_data_s = in_data[c*W +: W];
            end else begin
                xfer_data_s = xfer_data_s;
            end
        end
    end

    // packet lock: a non-last beat opens a lock, a last beat closes it
    always_comb begin
        state_nx = state_r;
        if (xfer_s) begin
            if (xfer_last_s) begin
                state_nx = IDLE;
            end else begin
                state_nx = LOCKED;
            end
        end else begin
            state_nx = state_r;
        end
    end

    // state, lock bookkeeping, round-robin pointer and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            lock_ch_r     <= '0;
            lock_forced_r <= 1'b0;
            rr_ptr_r      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_ch        <= '0;
        end else begin
            state_r <= state_nx;
            if (xfer_s && state_r == IDLE) begin
                lock_ch_r     <= grant_s;
                lock_forced_r <= force_en;
            end
            if (xfer_s && xfer_last_s && !pkt_forced_s) begin
                rr_ptr_r <= rr_next_s;
            end
            if (load_s) begin
                out_valid <= xfer_s;
                if (xfer_s) begin
                    out_data <= xfer_data_s;
                    out_last <= xfer_last_s;
                    out_ch   <= grant_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a round-robin 8-channel instance and a
// fixed-priority 7-channel instance, driven from per-channel source queues.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] d0_in_data;
    logic [7:0]  d0_in_valid, d0_in_last, d0_in_ready;
    logic        d0_force_en, d0_out_valid, d0_out_last, d0_out_ready;
    logic [2:0]  d0_force_sel, d0_out_ch;
    logic [7:0]  d0_out_data;

    logic [55:0] d1_in_data;
    logic [6:0]  d1_in_valid, d1_in_last, d1_in_ready;
    logic        d1_force_en, d1_out_valid, d1_out_last, d1_out_ready;
    logic [2:0]  d1_force_sel, d1_out_ch;
    logic [7:0]  d1_out_data;

    stream_mux_rr #(.NCH(8), .W(8), .SELW(3), .RR(1)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_last(d0_in_last), .in_ready(d0_in_ready), .force_en(d0_force_en),
        .force_sel(d0_force_sel), .out_data(d0_out_data), .out_valid(d0_out_valid),
        .out_last(d0_out_last), .out_ch(d0_out_ch), .out_ready(d0_out_ready)
    );

    stream_mux_rr #(.NCH(7), .W(8), .SELW(3), .RR(0)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_last(d1_in_last), .in_ready(d1_in_ready), .force_en(d1_force_en),
        .force_sel(d1_force_sel), .out_data(d1_out_data), .out_valid(d1_out_valid),
        .out_last(d1_out_last), .out_ch(d1_out_ch), .out_ready(d1_out_ready)
    );

    int checks = 0;
    int failures = 0;
    logic [8:0]  srcq [16][$];   // {last, data}; index 0..7 dut0, 8..14 dut1
    logic [11:0] exp0 [$];       // {ch, last, data}
    logic [11:0] exp1 [$];
    logic [7:0]  hold0 = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic src(input int q, input logic last, input logic [7:0] data);
        srcq[q].push_back({last, data});
    endtask

    task automatic p0(input logic [2:0] ch, input logic last, input logic [7:0] data);
        exp0.push_back({ch, last, data});
    endtask

    task automatic p1(input logic [2:0] ch, input logic last, input logic [7:0] data);
        exp1.push_back({ch, last, data});
    endtask

    task automatic redrive();
        for (int c = 0; c < 8; c++) begin
            if (srcq[c].size() != 0 && !hold0[c]) begin
                d0_in_valid[c]      = 1'b1;
                d0_in_data[c*8 +: 8] = srcq[c][0][7:0];
                d0_in_last[c]       = srcq[c][0][8];
            end else begin
                d0_in_valid[c]      = 1'b0;
                d0_in_data[c*8 +: 8] = 8'h00;
                d0_in_last[c]       = 1'b0;
            end
        end
        for (int c = 0; c < 7; c++) begin
            if (srcq[8+c].size() != 0) begin
                d1_in_valid[c]      = 1'b1;
                d1_in_data[c*8 +: 8] = srcq[8+c][0][7:0];
                d1_in_last[c]       = srcq[8+c][0][8];
            end else begin
                d1_in_valid[c]      = 1'b0;
                d1_in_data[c*8 +: 8] = 8'h00;
                d1_in_last[c]       = 1'b0;
            end
        end
    endtask

    task automatic step(input int n);
        logic [7:0] a0;
        logic [6:0] a1;
        logic [8:0] junk;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a0 = d0_in_ready & d0_in_valid;
            a1 = d1_in_ready & d1_in_valid;
            @(posedge clk);
            #1;
            for (int c = 0; c < 8; c++) if (a0[c]) junk = srcq[c].pop_front();
            for (int c = 0; c < 7; c++) if (a1[c]) junk = srcq[8+c].pop_front();
            redrive();
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
            step(1);
            n++;
        end
        chk(name, exp0.size() + exp1.size(), 0);
    endtask

    function automatic int pending0();
        int s;
        s = 0;
        for (int c = 0; c < 8; c++) s += srcq[c].size();
        return s;
    endfunction

    // monitor: a beat retires on the next edge whenever valid and ready are both high here
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && d0_out_valid && d0_out_ready) begin
                if (exp0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d0_extra_beat actual=%0h required=none", {d0_out_ch, d0_out_last, d0_out_data});
                end else begin
                    e = exp0.pop_front();
                    chk("d0_beat", {d0_out_ch, d0_out_last, d0_out_data}, e);
                end
            end
            if (!rst && d1_out_valid && d1_out_ready) begin
                if (exp1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d1_extra_beat actual=%0h required=none", {d1_out_ch, d1_out_last, d1_out_data});
                end else begin
                    e = exp1.pop_front();
                    chk("d1_beat", {d1_out_ch, d1_out_last, d1_out_data}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d0_in_data = '0; d0_in_last = '0; d0_force_en = 1'b0; d0_force_sel = 3'd0; d0_out_ready = 1'b1;
        d1_in_data = '0; d1_in_last = '0; d1_force_en = 1'b0; d1_force_sel = 3'd0; d1_out_ready = 1'b1;
        d0_in_valid = 8'hff;
        d1_in_valid = 7'h00;
        #12;
        chk("reset_out_valid", d0_out_valid, 0);
        chk("reset_in_ready", d0_in_ready, 0);
        chk("reset_out_data", d0_out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        redrive();
        step(3);
        chk("idle_no_valid", d0_out_valid, 0);

        // round robin, all channels valid, single-beat packets
        for (int c = 0; c < 8; c++) begin
            src(c, 1'b1, 8'hA0 + 8'(c));
            p0(3'(c), 1'b1, 8'hA0 + 8'(c));
        end
        src(0, 1'b1, 8'hB0); p0(3'd0, 1'b1, 8'hB0);
        redrive();
        step(9);
        chk("rr_throughput", pending0(), 0);
        drain("rr_drain");

        // ch2 four-beat packet with a bubble while ch0 and ch3 compete
        src(2, 1'b0, 8'h20); src(2, 1'b0, 8'h21); src(2, 1'b0, 8'h22); src(2, 1'b1, 8'h23);
        src(0, 1'b1, 8'h01); src(0, 1'b1, 8'h02); src(0, 1'b1, 8'h03);
        src(3, 1'b1, 8'h30);
        p0(3'd2, 1'b0, 8'h20); p0(3'd2, 1'b0, 8'h21); p0(3'd2, 1'b0, 8'h22); p0(3'd2, 1'b1, 8'h23);
        p0(3'd3, 1'b1, 8'h30);
        p0(3'd0, 1'b1, 8'h01); p0(3'd0, 1'b1, 8'h02); p0(3'd0, 1'b1, 8'h03);
        redrive();
        step(2);
        hold0 = 8'h04;
        redrive();
        #1;
        chk("lock_bubble_ready", d0_in_ready, 0);
        step(1);
        hold0 = 8'h00;
        redrive();
        drain("lock_drain");

        // backpressure mid-packet
        src(4, 1'b0, 8'h40); src(4, 1'b0, 8'h41); src(4, 1'b1, 8'h42);
        p0(3'd4, 1'b0, 8'h40); p0(3'd4, 1'b0, 8'h41); p0(3'd4, 1'b1, 8'h42);
        redrive();
        step(1);
        d0_out_ready = 1'b0;
        redrive();
        #1;
        chk("bp_in_ready", d0_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            #1;
            chk("bp_out_data", d0_out_data, 8'h40);
            chk("bp_out_ch", d0_out_ch, 3'd4);
            chk("bp_out_last", d0_out_last, 1'b0);
            chk("bp_in_ready_hold", d0_in_ready, 0);
        end
        d0_out_ready = 1'b1;
        drain("bp_drain");

        // forced select of ch2; afterwards arbitration resumes from the unforced pointer (5)
        d0_force_en = 1'b1;
        d0_force_sel = 3'd2;
        for (int c = 0; c < 8; c++) src(c, 1'b1, 8'h60 + 8'(c));
        src(2, 1'b1, 8'h72);
        p0(3'd2, 1'b1, 8'h62); p0(3'd2, 1'b1, 8'h72);
        p0(3'd5, 1'b1, 8'h65); p0(3'd6, 1'b1, 8'h66); p0(3'd7, 1'b1, 8'h67);
        p0(3'd0, 1'b1, 8'h60); p0(3'd1, 1'b1, 8'h61); p0(3'd3, 1'b1, 8'h63); p0(3'd4, 1'b1, 8'h64);
        redrive();
        step(4);
        chk("force_others_untouched", pending0(), 7);
        d0_force_en = 1'b0;
        redrive();
        drain("force_drain");

        // force raised mid-packet must not break the ch6 lock
        src(6, 1'b0, 8'h80); src(6, 1'b0, 8'h81); src(6, 1'b1, 8'h82);
        src(1, 1'b1, 8'h90);
        p0(3'd6, 1'b0, 8'h80); p0(3'd6, 1'b0, 8'h81); p0(3'd6, 1'b1, 8'h82); p0(3'd1, 1'b1, 8'h90);
        redrive();
        step(1);
        d0_force_en = 1'b1;
        d0_force_sel = 3'd1;
        redrive();
        #1;
        chk("force_lock_ready", d0_in_ready, 8'h40);
        drain("force_lock_drain");
        d0_force_en = 1'b0;

        // reset in the middle of a ch3 packet
        src(3, 1'b0, 8'h33); src(3, 1'b1, 8'h34);
        redrive();
        step(1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", d0_out_valid, 0);
        chk("rst_out_data", d0_out_data, 0);
        chk("rst_out_ch", d0_out_ch, 0);
        chk("rst_in_ready", d0_in_ready, 0);
        srcq[3].delete();
        redrive();
        step(2);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", d0_out_valid, 0);
        src(5, 1'b1, 8'h55); p0(3'd5, 1'b1, 8'h55);
        redrive();
        drain("post_rst_drain");

        // fixed priority: ch1 beats ch6 while it has data
        src(9, 1'b1, 8'h11); src(9, 1'b1, 8'h12); src(9, 1'b1, 8'h13);
        src(14, 1'b1, 8'h61); src(14, 1'b1, 8'h62);
        p1(3'd1, 1'b1, 8'h11); p1(3'd1, 1'b1, 8'h12); p1(3'd1, 1'b1, 8'h13);
        p1(3'd6, 1'b1, 8'h61); p1(3'd6, 1'b1, 8'h62);
        redrive();
        step(3);
        chk("prio_ch6_waits", srcq[14].size(), 2);
        drain("prio_drain");

        // forced index beyond the channel count grants nothing
        d1_force_en = 1'b1;
        d1_force_sel = 3'd7;
        src(8, 1'b1, 8'h01);
        redrive();
        #1;
        chk("force_oor_ready", d1_in_ready, 0);
        step(3);
        chk("force_oor_no_out", d1_out_valid, 0);
        chk("force_oor_pending", srcq[8].size(), 1);
        d1_force_en = 1'b0;
        p1(3'd0, 1'b1, 8'h01);
        redrive();
        drain("force_oor_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
